// File: rtl/player_bullet_ctrl.sv
// player_bullet_ctrl: owns the player's single bullet.
//   Launches on a fire press, climbs SPEED pixels per frame_tick, retires on an
//   enemy hit or on leaving the top of the screen, then waits COOLDOWN_FRAMES
//   frames before the next shot is allowed. Also renders the bullet pixel.
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per frame
//   fire                  debounced fire button (level)
//   player_x, player_y    player sprite top-left corner
//   hit                   OR of all enemy collision flags
//   h_counter, v_counter  current pixel being drawn
//   bullet_x, bullet_y    bullet top-left corner, PARK when not in flight
//   active                1 while the bullet is in flight
//   shots, kills          saturating launch / hit counters
//   R, G, B               bullet pixel colour, one cycle after h/v_counter
module player_bullet_ctrl #(
    parameter int unsigned SPEED           = 4,
    parameter int unsigned BULLET_W        = 2,
    parameter int unsigned BULLET_H        = 6,
    parameter int unsigned MUZZLE_DX       = 11,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned PARK            = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       hit,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       active,
    output logic [7:0] shots,
    output logic [7:0] kills,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CMP_W = POS_W + 1;

    localparam logic [POS_W-1:0] PARK_V   = POS_W'(PARK);
    localparam logic [POS_W-1:0] SPEED_V  = POS_W'(SPEED);
    localparam logic [POS_W-1:0] HEIGHT_V = POS_W'(BULLET_H);
    localparam logic [POS_W-1:0] MUZZLE_V = POS_W'(MUZZLE_DX);
    localparam logic [CNT_W-1:0] CD_V     = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] SAT_V    = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLYING   = 2'd1;
    localparam logic [1:0] S_COOLDOWN = 2'd2;

    logic [1:0]       state, state_nx;
    logic             fire_q;
    logic             fire_rise;
    logic [CNT_W-1:0] cd_cnt, cd_nx;
    logic [POS_W-1:0] bx_nx, by_nx;
    logic [CNT_W-1:0] shots_nx, kills_nx;
    logic             pix_on;

    assign fire_rise = fire & ~fire_q;

    // Next-state and next-value logic for the bullet FSM.
    always_comb begin
        state_nx = state;
        bx_nx    = bullet_x;
        by_nx    = bullet_y;
        shots_nx = shots;
        kills_nx = kills;
        cd_nx    = cd_cnt;
        case (state)
            S_IDLE: begin
                if (fire_rise) begin
                    state_nx = S_FLYING;
                    if (shots != SAT_V) shots_nx = shots + CNT_W'(1);
                    bx_nx = player_x + MUZZLE_V;
                    // Clamp at the top row instead of wrapping.
                    by_nx = (player_y < HEIGHT_V) ? '0 : player_y - HEIGHT_V;
                end
            end
            S_FLYING: begin
                // Hit takes priority over the frame move.
                if (hit) begin
                    state_nx = S_COOLDOWN;
                    if (kills != SAT_V) kills_nx = kills + CNT_W'(1);
                    bx_nx = PARK_V;
                    by_nx = PARK_V;
                    cd_nx = CD_V;
                end else if (frame_tick) begin
                    if (bullet_y < SPEED_V) begin
                        state_nx = S_COOLDOWN;
                        bx_nx    = PARK_V;
                        by_nx    = PARK_V;
                        cd_nx    = CD_V;
                    end else begin
                        by_nx = bullet_y - SPEED_V;
                    end
                end
            end
            S_COOLDOWN: begin
                if (cd_cnt == '0) begin
                    state_nx = S_IDLE;
                end else if (frame_tick) begin
                    cd_nx = cd_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                bx_nx    = PARK_V;
                by_nx    = PARK_V;
            end
        endcase
    end

    // Pixel hit test at 11 bits so bullet_x+W / bullet_y+H cannot wrap.
    always_comb begin
        pix_on = active
            && ({1'b0, h_counter} >= {1'b0, bullet_x})
            && ({1'b0, h_counter} <  ({1'b0, bullet_x} + CMP_W'(BULLET_W)))
            && ({1'b0, v_counter} >= {1'b0, bullet_y})
            && ({1'b0, v_counter} <  ({1'b0, bullet_y} + CMP_W'(BULLET_H)));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            fire_q   <= 1'b1;
            cd_cnt   <= '0;
            bullet_x <= PARK_V;
            bullet_y <= PARK_V;
            active   <= 1'b0;
            shots    <= '0;
            kills    <= '0;
            R        <= '0;
            G        <= '0;
            B        <= '0;
        end else begin
            state    <= state_nx;
            fire_q   <= fire;
            cd_cnt   <= cd_nx;
            bullet_x <= bx_nx;
            bullet_y <= by_nx;
            active   <= (state_nx == S_FLYING);
            shots    <= shots_nx;
            kills    <= kills_nx;
            R        <= pix_on ? 8'hFF : 8'h00;
            G        <= pix_on ? 8'hFF : 8'h00;
            B        <= 8'h00;
        end
    end

endmodule

// File: doc/player_bullet_ctrl.md
Name: player_bullet_ctrl

Overview:
- Owns the player's single bullet: launches it from the ship on a fire press and moves it upward once per video frame.
- Retires the bullet on an enemy collision report or when it leaves the top of the screen.
- Drives the bullet position consumed by every enemy block's collision check, and renders the bullet pixel colour for the VGA mixer.
- Sits between player input/position logic, the enemy blocks (their collision outputs ORed into hit) and the colour mux.

Parameters:
SPEED, 4, pixels moved up per frame_tick
BULLET_W, 2, bullet width in pixels
BULLET_H, 6, bullet height in pixels
MUZZLE_DX, 11, x offset from player_x to the bullet's left edge
COOLDOWN_FRAMES, 8, frame_ticks after retirement before next shot allowed (0 = none)
PARK, 1023, x/y value driven while no bullet is in flight (off-screen)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (end of visible area)
fire  in  1  fire button, active-high level, already debounced
player_x  in  10  player sprite left edge
player_y  in  10  player sprite top edge
hit  in  1  OR of all enemy collision flags
h_counter  in  10  current pixel column
v_counter  in  10  current pixel row
bullet_x  out  10  bullet left edge, PARK when inactive
bullet_y  out  10  bullet top edge, PARK when inactive
active  out  1  1 while state FLYING
shots  out  8  shots launched, saturates at 255
kills  out  8  hits registered, saturates at 255
R  out  8  bullet pixel red
G  out  8  bullet pixel green
B  out  8  bullet pixel blue

Behaviour:
- Reset values:
  - state = IDLE; bullet_x = bullet_y = PARK; active = 0.
  - shots = kills = 0; R = G = B = 0; cooldown counter = 0.
  - fire_q = 1, so a fire held through reset release does not launch.
- Edge detect: fire_rise = fire & ~fire_q; fire_q <= fire every cycle.
- FSM states are IDLE, FLYING, COOLDOWN.
- IDLE, when fire_rise:
  - Go to FLYING and increment shots (saturating).
  - bullet_x <= player_x + MUZZLE_DX, truncated to 10 bits.
  - bullet_y <= player_y - BULLET_H, or 0 if player_y < BULLET_H.
  - active = 1 from the next cycle onward.
- FLYING, priority order:
  - hit: go to COOLDOWN, kills++ (saturating), bullet_x/bullet_y <= PARK.
  - else frame_tick with bullet_y < SPEED: go to COOLDOWN, park, kills unchanged.
  - else frame_tick: bullet_y <= bullet_y - SPEED.
  - fire_rise is ignored; there is no shot queue.
  - hit and frame_tick in the same cycle: hit wins, and the position is not updated.
- COOLDOWN entry: counter <= COOLDOWN_FRAMES.
- COOLDOWN, each cycle:
  - Counter == 0: go to IDLE.
  - Else on frame_tick: counter decrements.
  - fire_rise is ignored.
  - With COOLDOWN_FRAMES = 0, exactly one cycle is spent in COOLDOWN.
- hit outside FLYING: ignored, counters unchanged.
- Rendering (1-cycle registered latency):
  - Next cycle RGB = FF,FF,00 when active, h_counter in [bullet_x, bullet_x+BULLET_W) and v_counter in [bullet_y, bullet_y+BULLET_H).
  - Otherwise RGB = 0.
  - Compare at 11 bits so the right/bottom bound cannot wrap.
- Reset mid-flight: next cycle equals the reset values above.

Test Plan:
1. Launch:
   - Reset, player_x=100, player_y=440; pulse fire for 1 cycle.
   - Expect: next cycle active=1, bullet_x=111, bullet_y=434, shots=1.
   - Holding fire for 50 cycles gives shots=1 only.
2. Flight and exit:
   - After scenario 1, apply frame_ticks.
   - Expect: bullet_y 430, 426, ...
   - After the tick that sees bullet_y=2 (<4), active=0 and bullet_x=bullet_y=1023; kills=0.
   - fire_rise during the next 8 frame_ticks is ignored; after the 8th tick, state returns to IDLE and a fire press launches.
3. Hit:
   - While flying at bullet_y=300, assert hit together with frame_tick.
   - Expect: next cycle bullet parked, kills=1, no position update to 296.
   - hit pulsed again in COOLDOWN leaves kills=1.
4. Edge clamp:
   - player_y=3; fire.
   - Expect: bullet_y=0, then retirement on the first frame_tick.
5. Render:
   - Bullet at (111,434); sweep h=110..113, v=433..440.
   - Expect RGB=FFFF00 one cycle after samples h∈{111,112}, v∈{434..439}; 0 elsewhere and while inactive.
6. Reset mid-flight and saturation:
   - Assert reset during FLYING; expect all outputs at reset values next cycle, and fire held across reset not launching.
   - 256 launches give shots=255.
